// File: rtl/alu_fib_driver.sv
// Fibonacci sequencer acting as sole master of a registered add ALU.
// Emits seeds, then one ALU sum per (1+ALU_LAT) cycles, stopping on term limit or ALU flag.
module alu_fib_driver #(
  parameter int W       = 6,
  parameter int N_TERMS = 16,
  parameter int ALU_LAT = 1,
  parameter int IDXW    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [W-1:0]    init0,
  input  logic [W-1:0]    init1,
  output logic            busy,
  output logic [2:0]      alu_s,
  output logic [W-1:0]    alu_a,
  output logic [W-1:0]    alu_b,
  input  logic [W-1:0]    alu_result,
  input  logic [1:0]      alu_f,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic [IDXW-1:0] out_idx,
  output logic            done,
  output logic            ovf,
  output logic            err
);

  typedef enum logic [2:0] {IDLE, EMIT1, ISSUE, RESP, DONE} state_t;

  localparam logic [1:0]    CNT_LOAD = 2'(ALU_LAT - 1);
  localparam logic [IDXW:0] LAST_IDX = (IDXW + 1)'(N_TERMS - 1);

  state_t          state, state_n;
  logic [W-1:0]    a, b, a_n, b_n;
  logic [W-1:0]    alu_a_n, alu_b_n, out_data_n;
  logic [IDXW-1:0] out_idx_n;
  logic [IDXW:0]   idx_inc;
  logic [1:0]      cnt, cnt_n;
  logic            out_valid_n, done_n, ovf_n, err_n;

  assign alu_s   = 3'b000;
  assign busy    = (state != IDLE);
  assign idx_inc = {1'b0, out_idx} + (IDXW + 1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      b         <= '0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      a         <= a_n;
      b         <= b_n;
      cnt       <= cnt_n;
      alu_a     <= alu_a_n;
      alu_b     <= alu_b_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_idx   <= out_idx_n;
      done      <= done_n;
      ovf       <= ovf_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    a_n         = a;
    b_n         = b;
    cnt_n       = cnt;
    alu_a_n     = alu_a;
    alu_b_n     = alu_b;
    out_valid_n = 1'b0;
    out_data_n  = out_data;
    out_idx_n   = out_idx;
    done_n      = 1'b0;
    ovf_n       = ovf;
    err_n       = err;
    case (state)
      IDLE: begin
        if (start) begin
          a_n         = init0;
          b_n         = init1;
          ovf_n       = 1'b0;
          err_n       = 1'b0;
          out_valid_n = 1'b1;
          out_data_n  = init0;
          out_idx_n   = '0;
          state_n     = EMIT1;
        end
      end
      EMIT1: begin
        out_valid_n = 1'b1;
        out_data_n  = b;
        out_idx_n   = IDXW'(1);
        if (N_TERMS == 2) begin
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          alu_a_n = a;
          alu_b_n = b;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        cnt_n   = CNT_LOAD;
        state_n = RESP;
      end
      RESP: begin
        if (cnt != 2'd0) begin
          cnt_n = cnt - 2'd1;
        end else begin
          case (alu_f)
            2'b01: begin
              ovf_n   = 1'b1;
              done_n  = 1'b1;
              state_n = DONE;
            end
            2'b10: begin
              err_n   = 1'b1;
              done_n  = 1'b1;
              state_n = DONE;
            end
            default: begin
              // done is raised together with the final strobe so it is visible while in DONE
              out_valid_n = 1'b1;
              out_data_n  = alu_result;
              out_idx_n   = idx_inc[IDXW-1:0];
              a_n         = b;
              b_n         = alu_result;
              alu_a_n     = b;
              alu_b_n     = alu_result;
              if (idx_inc == LAST_IDX) begin
                done_n  = 1'b1;
                state_n = DONE;
              end else begin
                state_n = ISSUE;
              end
            end
          endcase
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_fib_driver.sv
// Bench for alu_fib_driver: four instances with different N_TERMS/ALU_LAT, each driving a bench ALU model.
module tb_alu_fib_driver;

  localparam int NI = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       force_err = 1'b0;

  logic       start [NI];
  logic [5:0] init0 [NI];
  logic [5:0] init1 [NI];
  logic       busy [NI];
  logic [2:0] alu_s [NI];
  logic [5:0] alu_a [NI];
  logic [5:0] alu_b [NI];
  logic [5:0] alu_result [NI];
  logic [1:0] alu_f [NI];
  logic       out_valid [NI];
  logic [5:0] out_data [NI];
  logic [4:0] out_idx [NI];
  logic       done [NI];
  logic       ovf [NI];
  logic       err [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int NT = (g == 0) ? 16 : (g == 1) ? 5 : 4;
    localparam int LT = (g == 3) ? 3 : 1;
    alu_fib_driver #(.W(6), .N_TERMS(NT), .ALU_LAT(LT), .IDXW(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .init0(init0[g]), .init1(init1[g]),
      .busy(busy[g]), .alu_s(alu_s[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]),
      .alu_result(alu_result[g]), .alu_f(alu_f[g]), .out_valid(out_valid[g]),
      .out_data(out_data[g]), .out_idx(out_idx[g]), .done(done[g]), .ovf(ovf[g]), .err(err[g])
    );
  end

  // Registered 6-bit add ALU; instance 3 delays the result by two extra stages.
  function automatic logic [7:0] alu_add(input logic [5:0] x, input logic [5:0] y, input logic ferr);
    logic [6:0] s;
    logic [1:0] f;
    s = {1'b0, x} + {1'b0, y};
    if (ferr)              f = 2'b10;
    else if (s[6])         f = 2'b01;
    else if (s[5:0] == 0)  f = 2'b11;
    else                   f = 2'b00;
    return {f, s[5:0]};
  endfunction

  logic [7:0] pipe [NI][3];

  always_ff @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        pipe[i][0] <= '0;
        pipe[i][1] <= '0;
        pipe[i][2] <= '0;
      end else begin
        pipe[i][0] <= alu_add(alu_a[i], alu_b[i], force_err && (i == 0));
        pipe[i][1] <= pipe[i][0];
        pipe[i][2] <= pipe[i][1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      alu_result[i] = pipe[i][(i == 3) ? 2 : 0][5:0];
      alu_f[i]      = pipe[i][(i == 3) ? 2 : 0][7:6];
    end
  end

  // Output monitor, sampled on the falling edge.
  int         cyc = 0;
  int         cap_n [NI] = '{default: 0};
  logic [5:0] cap_data [NI][64];
  int         cap_idx [NI][64];
  int         cap_cyc [NI][64];
  int         done_cnt [NI] = '{default: 0};
  int         done_cyc [NI] = '{default: 0};
  logic       prev_done [NI] = '{default: 1'b0};
  logic       busy_after [NI] = '{default: 1'b0};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NI; i++) begin
      if (out_valid[i] && cap_n[i] < 64) begin
        cap_data[i][cap_n[i]] <= out_data[i];
        cap_idx[i][cap_n[i]]  <= int'(out_idx[i]);
        cap_cyc[i][cap_n[i]]  <= cyc;
        cap_n[i]              <= cap_n[i] + 1;
      end
      if (done[i]) begin
        done_cnt[i] <= done_cnt[i] + 1;
        done_cyc[i] <= cyc;
      end
      if (prev_done[i]) busy_after[i] <= busy[i];
      prev_done[i] <= done[i];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         inst;
    logic [5:0] i0;
    logic [5:0] i1;
    int         n;
    logic       eovf;
    logic       eerr;
    int         lat;
    int         done_off;
    logic       poke;
    logic       ferr;
  } vec_t;

  localparam int NV = 7;
  vec_t       vecs [NV];
  logic [5:0] exp_terms [NV][12];

  task automatic run_vec(input int v);
    int i, base, dbase, t, got, last;
    i     = vecs[v].inst;
    base  = cap_n[i];
    dbase = done_cnt[i];
    @(negedge clk);
    force_err = vecs[v].ferr;
    init0[i]  = vecs[v].i0;
    init1[i]  = vecs[v].i1;
    start[i]  = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    if (vecs[v].poke) begin
      repeat (4) @(negedge clk);
      init0[i] = 6'd7;
      init1[i] = 6'd7;
      start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
    end
    t = 0;
    while (done_cnt[i] == dbase && t < 300) begin
      @(posedge clk);
      t++;
    end
    chk($sformatf("v%0d done_seen", v), int'(t < 300), 1);
    repeat (3) @(negedge clk);
    force_err = 1'b0;
    got = cap_n[i] - base;
    chk($sformatf("v%0d term_count", v), got, vecs[v].n);
    if (got == vecs[v].n) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        chk($sformatf("v%0d data[%0d]", v, k), int'(cap_data[i][base+k]), int'(exp_terms[v][k]));
        chk($sformatf("v%0d idx[%0d]", v, k), cap_idx[i][base+k], k);
        if (k > 0)
          chk($sformatf("v%0d gap[%0d]", v, k), cap_cyc[i][base+k] - cap_cyc[i][base+k-1],
              (k == 1) ? 1 : 1 + vecs[v].lat);
      end
      last = base + vecs[v].n - 1;
      chk($sformatf("v%0d done_offset", v), done_cyc[i] - cap_cyc[i][last], vecs[v].done_off);
    end
    chk($sformatf("v%0d done_pulses", v), done_cnt[i] - dbase, 1);
    chk($sformatf("v%0d ovf", v), int'(ovf[i]), int'(vecs[v].eovf));
    chk($sformatf("v%0d err", v), int'(err[i]), int'(vecs[v].eerr));
    chk($sformatf("v%0d busy_after_done", v), int'(busy_after[i]), 0);
    chk($sformatf("v%0d busy_idle", v), int'(busy[i]), 0);
  endtask

  initial begin
    int base, dbase;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      init0[i] = '0;
      init1[i] = '0;
    end
    vecs[0] = '{0, 6'd0, 6'd1, 11, 1'b1, 1'b0, 1, 2, 1'b0, 1'b0};
    vecs[1] = '{1, 6'd1, 6'd0,  5, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0};
    vecs[2] = '{2, 6'd0, 6'd0,  4, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0};
    vecs[3] = '{0, 6'd3, 6'd4,  2, 1'b0, 1'b1, 1, 2, 1'b0, 1'b1};
    vecs[4] = '{0, 6'd1, 6'd1, 10, 1'b1, 1'b0, 1, 2, 1'b0, 1'b0};
    vecs[5] = '{0, 6'd0, 6'd1, 11, 1'b1, 1'b0, 1, 2, 1'b1, 1'b0};
    vecs[6] = '{3, 6'd2, 6'd3,  4, 1'b0, 1'b0, 3, 0, 1'b0, 1'b0};
    exp_terms[0] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 0};
    exp_terms[1] = '{1, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0};
    exp_terms[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_terms[3] = '{3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_terms[4] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 0, 0};
    exp_terms[5] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 0};
    exp_terms[6] = '{2, 3, 5, 8, 0, 0, 0, 0, 0, 0, 0, 0};

    #2;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst%0d busy", i), int'(busy[i]), 0);
      chk($sformatf("rst%0d out_valid", i), int'(out_valid[i]), 0);
      chk($sformatf("rst%0d done", i), int'(done[i]), 0);
      chk($sformatf("rst%0d ovf_err", i), int'({ovf[i], err[i]}), 0);
      chk($sformatf("rst%0d out_data_idx", i), int'({out_data[i], out_idx[i]}), 0);
      chk($sformatf("rst%0d alu_ab", i), int'({alu_a[i], alu_b[i]}), 0);
      chk($sformatf("rst%0d alu_s", i), int'(alu_s[i]), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < NV; v++) run_vec(v);

    // Asynchronous reset while waiting on the first ALU response.
    base  = cap_n[0];
    dbase = done_cnt[0];
    init0[0] = 6'd0;
    init1[0] = 6'd1;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid busy_before_reset", int'(busy[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid busy", int'(busy[0]), 0);
    chk("mid out_data", int'(out_data[0]), 0);
    chk("mid out_idx", int'(out_idx[0]), 0);
    chk("mid alu_b", int'(alu_b[0]), 0);
    chk("mid out_valid_done", int'({out_valid[0], done[0]}), 0);
    chk("mid ovf_err", int'({ovf[0], err[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid no_done", done_cnt[0] - dbase, 0);
    chk("mid strobes", cap_n[0] - base, 2);
    chk("mid idle", int'(busy[0]), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_fib_driver.md
Name: alu_fib_driver

Overview:
- Initiator-side sequencer for the registered 6-bit ALU.
- Drives opcode/operands into the ALU and consumes its result and flags, using repeated add to generate a Fibonacci-style sequence from two seed values.
- Emits each term on a valid-strobed output stream.
- Stops on term limit, ALU overflow flag, or an unexpected flag (protocol error).
- Sits between control logic/switches and the ALU instance, as its sole master.

Parameters:
- W, 6, data width; must match the ALU operand/result width.
- N_TERMS, 16, total terms to emit including both seeds; legal range 2..(2^IDXW).
- ALU_LAT, 1, cycles from ALU capture edge to the edge where result/f are sampled; range 1..4.
- IDXW, 5, width of the term index.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- init0  in  W  seed term 0; sampled with start.
- init1  in  W  seed term 1; sampled with start.
- busy  out  1  high in every state except IDLE.
- alu_s  out  3  ALU opcode; constant 3'b000 (add).
- alu_a  out  W  ALU operand a, registered.
- alu_b  out  W  ALU operand b, registered.
- alu_result  in  W  ALU result, registered inside the ALU.
- alu_f  in  2  ALU flags: 00 normal, 01 overflow/carry, 10 borrow, 11 zero.
- out_valid  out  1  one-cycle strobe; out_data/out_idx valid this cycle.
- out_data  out  W  emitted term.
- out_idx  out  IDXW  index of emitted term, 0-based.
- done  out  1  one-cycle pulse at sequence end.
- ovf  out  1  sticky: sequence ended on ALU overflow.
- err  out  1  sticky: sequence ended on an illegal flag (10).

Behaviour:
- Reset (async, any state): state=IDLE; alu_s=000; alu_a=alu_b=0; out_valid=0; out_data=0; out_idx=0; done=0; ovf=0; err=0; busy=0; internal regs cleared.
- All outputs are registered; busy is decoded from state.
- States: IDLE, EMIT1, ISSUE, RESP, DONE.
- IDLE:
  - start=1 at edge E0: latch a=init0, b=init1; clear ovf/err.
  - Set out_valid=1, out_data=init0, out_idx=0; go to EMIT1.
  - start=0: stay in IDLE.
- EMIT1 (edge leaving it):
  - Set out_valid=1, out_data=init1, out_idx=1.
  - If N_TERMS==2, go to DONE.
  - Otherwise drive alu_a=a, alu_b=b and go to ISSUE.
- ISSUE:
  - Operands stable for the whole cycle; the ALU captures at the edge leaving ISSUE.
  - Go to RESP; load latency counter with ALU_LAT-1.
- RESP:
  - Count down. On the edge where the counter is 0, sample alu_result/alu_f.
  - alu_f==01: no emission; ovf<=1; go to DONE. The wrapped value is never emitted.
  - alu_f==10: no emission; err<=1; go to DONE.
  - alu_f==00 or 11 (zero is legal): out_valid<=1, out_data<=alu_result, out_idx<=out_idx+1; a<=b, b<=alu_result; alu_a/alu_b updated to the new pair.
  - Then, if out_idx+1==N_TERMS-1, go to DONE; else go to ISSUE.
- DONE: done=1 for exactly one cycle; go to IDLE. ovf/err hold until the next accepted start.
- out_valid is 0 in every cycle not listed above.
- Term throughput after the seeds: one term per (1+ALU_LAT) cycles.
- Timing at ALU_LAT=1, start at E0:
  - init0 valid after E0.
  - init1 valid after E1.
  - Term 2 valid after E3.
  - Term k valid after E(2k-1).
- Arithmetic is unsigned W-bit. Overflow detection relies solely on alu_f; the block does no independent check.
- start while busy is ignored, with no effect on seeds or state.
- start asserted in the DONE cycle is ignored; a new sequence needs start high in IDLE.
- Reset mid-sequence aborts immediately with no done pulse; ovf/err are cleared.
- The index never wraps, since N_TERMS ≤ 2^IDXW.

Test Plan:
1. init0=0, init1=1, N_TERMS=16, real ALU → out_data 0,1,1,2,3,5,8,13,21,34,55 at idx 0..10; next add (34+55=89) flags 01 → no 12th strobe, done pulse, ovf=1, err=0, busy drops the cycle after done.
2. init0=1, init1=0, N_TERMS=5 → 1,0,1,1,2 (idx 0..4); done pulses after idx 4; ovf=0. Check spacing: seeds on consecutive cycles, computed terms 2 cycles apart.
3. init0=0, init1=0, N_TERMS=4 → 0,0,0,0 with alu_f=11 accepted as legal; done, ovf=0, err=0.
4. Stub ALU forces alu_f=10 on the first add (init 3,4) → emits 3,4 only; err=1, done pulse. A following start with init 1,1 clears err and emits 1,1,2,...
5. Pulse start again during term 3 of scenario 1 → ignored; sequence unchanged. Assert rst_n=0 for 1 cycle mid-RESP → all outputs reset values immediately (async), state IDLE, no done.
6. ALU_LAT=3 with a delayed-result stub, init 2,3, N_TERMS=4 → 2,3,5,8; computed terms 4 cycles apart; out_idx 0..3.
